// File: rtl/ls_inv_filt_pkg.sv
// Shared constants and polarity type for the filtered inverter/buffer family.
// Used by ls_inv_filt and ls_inv_filt_ch (build option LS_INV_FILT_SYNC_EN).
package ls_pkg;

   localparam int unsigned LS_HEX_CHANNELS = 6;
   localparam int unsigned LS_FILT_CNT_DEF = 4;

   typedef enum logic {
      LS_BUF = 1'b0,
      LS_INV = 1'b1
   } ls_pol_e;

   function automatic logic ls_apply_pol(input logic s, input ls_pol_e p);
      return s ^ (p == LS_INV);
   endfunction

endpackage

// File: rtl/ls_inv_filt_ch.sv
// One channel: optional 2-flop synchroniser (LS_INV_FILT_SYNC_EN), persistence
// filter producing the accepted level s_o, and a one-cycle change pulse edge_o.
module ls_inv_filt_ch
   import ls_pkg::*;
#(
   parameter int unsigned FILT_CNT = LS_FILT_CNT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic hold_i,
   input  logic a_i,
   output logic s_o,
   output logic edge_o
);

   localparam int unsigned CW = $clog2(FILT_CNT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

   logic          sync;
   logic          s_q, s_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          edge_q, edge_d;

`ifdef LS_INV_FILT_SYNC_EN
   logic [1:0] sync_q;

   // Synchroniser keeps sampling while hold_i is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], a_i};
      end
   end

   assign sync = sync_q[1];
`else
   assign sync = a_i;
`endif

   always_comb begin
      s_d    = s_q;
      cnt_d  = cnt_q;
      edge_d = 1'b0;
      if (!hold_i) begin
         if (sync == s_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            s_d    = sync;
            cnt_d  = '0;
            edge_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q    <= 1'b0;
         cnt_q  <= '0;
         edge_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         cnt_q  <= cnt_d;
         edge_q <= edge_d;
      end
   end

   assign s_o    = s_q;
   assign edge_o = edge_q;

endmodule

// File: rtl/ls_inv_filt.sv
// N-channel glitch-filtered inverter/buffer; y = accepted level XOR polarity.
// Build option LS_INV_FILT_SYNC_EN adds a 2-flop input synchroniser per channel.
module ls_inv_filt
   import ls_pkg::*;
#(
   parameter int unsigned CHANNELS = LS_HEX_CHANNELS,
   parameter int unsigned FILT_CNT = LS_FILT_CNT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                hold_i,
   input  logic [CHANNELS-1:0] pol_i,
   input  logic [CHANNELS-1:0] a_i,
   output logic [CHANNELS-1:0] y_o,
   output logic [CHANNELS-1:0] edge_o
);

   logic [CHANNELS-1:0] s;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      ls_inv_filt_ch #(
         .FILT_CNT(FILT_CNT)
      ) u_ch (
         .clk   (clk),
         .rst   (rst),
         .hold_i(hold_i),
         .a_i   (a_i[g]),
         .s_o   (s[g]),
         .edge_o(edge_o[g])
      );

      // Polarity is combinational so a pol change never touches edge_o.
      assign y_o[g] = ls_apply_pol(s[g], ls_pol_e'(pol_i[g]));
   end

endmodule

// File: tb/tb_ls_inv_filt.sv
// Scoreboard bench for ls_inv_filt (CHANNELS=6, FILT_CNT=4); latency follows
// LS_INV_FILT_SYNC_EN when it is defined for the whole build.
module tb_ls_inv_filt;
   import ls_pkg::*;

   localparam int unsigned CH = 6;
   localparam int unsigned F  = 4;
`ifdef LS_INV_FILT_SYNC_EN
   localparam int unsigned LAT = 2;
`else
   localparam int unsigned LAT = 0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          hold;
   logic [CH-1:0] pol, a, y, edg;

   ls_inv_filt #(.CHANNELS(CH), .FILT_CNT(F)) dut (
      .clk   (clk),
      .rst   (rst),
      .hold_i(hold),
      .pol_i (pol),
      .a_i   (a),
      .y_o   (y),
      .edge_o(edg)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned   at;
      logic [CH-1:0] mask;
      logic [CH-1:0] yv;
   } exp_t;

   exp_t          q[$];
   int            tests = 0;
   int            fails = 0;
   logic [CH-1:0] s_m;
   int unsigned   k, k2;

   task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic check_int(input string name, input int unsigned act, input int unsigned expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic expect_edge(input int unsigned at, input logic [CH-1:0] mask);
      exp_t e;
      s_m    = s_m ^ mask;
      e.at   = at;
      e.mask = mask;
      e.yv   = s_m ^ pol;
      q.push_back(e);
   endtask

   // Monitor: every edge pulse must match the next expected acceptance.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (edg != '0) begin
         if (q.size() == 0) begin
            check("unexpected_edge", edg, '0);
         end else begin
            e = q.pop_front();
            check_int("edge_cycle", cyc, e.at);
            check("edge_mask", edg, e.mask);
            check("edge_y", y, e.yv);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      // 1: async reset state
      rst  = 1'b1;
      hold = 1'b0;
      pol  = 6'h3F;
      a    = '0;
      s_m  = '0;
      #1;
      check("rst_y", y, 6'h3F);
      check("rst_edge", edg, '0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("post_rst_y", y, 6'h3F);
      check("post_rst_edge", edg, '0);

      // 2: a[0] rises, full latency, single pulse
      @(negedge clk);
      a[0] = 1'b1;
      k = cyc + 1;
      expect_edge(k + LAT + F - 1, 6'b000001);
      repeat (LAT + F - 1) @(negedge clk);
      check("t2_pre_y", y, 6'h3F);
      @(negedge clk);
      check("t2_post_y", y, 6'h3E);
      repeat (3) @(negedge clk);
      check_int("t2_drained", q.size(), 0);

      // 3a: 3-cycle glitch on a[1] rejected
      @(negedge clk);
      a[1] = 1'b1;
      repeat (3) @(negedge clk);
      a[1] = 1'b0;
      repeat (LAT + F + 2) @(negedge clk);
      check("t3_glitch_y", y, 6'h3E);

      // 3b: 4-cycle pulse accepted, then the fall is accepted
      @(negedge clk);
      a[1] = 1'b1;
      k = cyc + 1;
      expect_edge(k + LAT + F - 1, 6'b000010);
      repeat (4) @(negedge clk);
      a[1] = 1'b0;
      k2 = cyc + 1;
      expect_edge(k2 + LAT + F - 1, 6'b000010);
      repeat (LAT + F + 2) @(negedge clk);
      check("t3_pulse_y", y, 6'h3E);
      check_int("t3_drained", q.size(), 0);

      // 4: hold freezes filter; release accepts after F edges
      @(negedge clk);
      hold = 1'b1;
      a[2] = 1'b1;
      repeat (10) @(negedge clk);
      check("t4_hold_y", y, 6'h3E);
      hold = 1'b0;
      k = cyc + 1;
      expect_edge(k + F - 1, 6'b000100);
      repeat (F + 1) @(negedge clk);
      check("t4_release_y", y, 6'h3A);
      check_int("t4_drained", q.size(), 0);

      // 5: polarity change is combinational and edge-free
      @(negedge clk);
      pol[3] = 1'b0;
      #1;
      check("t5_pol_y", y, 6'h32);
      check("t5_pol_edge", edg, '0);
      repeat (3) @(negedge clk);

      // 6: async reset mid-count restarts full latency
      @(negedge clk);
      a[4] = 1'b1;
      repeat (LAT + 2) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("t6_rst_y", y, pol);
      check("t6_rst_edge", edg, '0);
      s_m = '0;
      @(negedge clk);
      rst = 1'b0;
      k = cyc + 1;
      expect_edge(k + LAT + F - 1, a);
      repeat (LAT + F + 1) @(negedge clk);
      check("t6_final_y", y, a ^ pol);
      check_int("t6_drained", q.size(), 0);

      repeat (3) @(negedge clk);
      check_int("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
